// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer owning the cipher state and round counter
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  input  logic         rk_valid,
  output logic [127:0] dp_state,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  fsm_t         fsm, fsm_nx;
  logic [127:0] state_q, state_nx;
  logic [3:0]   round, round_nx;
  logic         last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm     <= IDLE;
      state_q <= '0;
      round   <= '0;
    end else begin
      fsm     <= fsm_nx;
      state_q <= state_nx;
      round   <= round_nx;
    end
  assign last      = round == LAST;
  assign in_ready  = fsm == IDLE && rk_valid;
  assign out_valid = fsm == DONE;
  assign busy      = fsm != IDLE;
  assign rk_idx    = fsm == ROUND ? round : 4'd0;
  assign dp_final  = fsm == ROUND && last;
  assign ct_out    = state_q;
  assign dp_state  = state_q;
  // A missing key stalls the round in place; the final round parks in DONE
  always_comb begin
    fsm_nx   = fsm;
    state_nx = state_q;
    round_nx = round;
    case (fsm)
      IDLE:
        if (in_valid && rk_valid) begin
          state_nx = pt_in ^ rk_in;
          round_nx = 4'd1;
          fsm_nx   = ROUND;
        end
      ROUND:
        if (rk_valid) begin
          state_nx = dp_result;
          fsm_nx   = last ? DONE : ROUND;
          round_nx = last ? round : round + 4'd1;
        end
      DONE:
        if (out_ready) begin
          fsm_nx   = IDLE;
          round_nx = '0;
        end
      default: fsm_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: behavioural key store and round datapath around the sequencer,
// with a ciphertext scoreboard and directed stall/backpressure/reset scenarios.
module tb_aes_round_ctrl;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ARK_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, rk_valid, dp_final, busy;
  logic [127:0] pt_in, ct_out, rk_in, dp_state, dp_result, next_exp, s_hold;
  logic [3:0]   rk_idx;
  logic [127:0] rk_tab [0:10];
  logic [127:0] sb [$];
  int           passed = 0, total = 0, cyc = 0, acc = 0, a1 = 0;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pt_in(pt_in),
    .out_valid(out_valid), .out_ready(out_ready), .ct_out(ct_out), .rk_idx(rk_idx),
    .rk_in(rk_in), .rk_valid(rk_valid), .dp_state(dp_state), .dp_final(dp_final),
    .dp_result(dp_result), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? (a << 1) ^ 8'h1b : a << 1;
      b = b >> 1;
    end
    return p;
  endfunction

  // Inverse as x^254, then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01, sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x [4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin)
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) x[r] = b[r+4*c];
        b[4*c]   = gmul(8'h02, x[0]) ^ gmul(8'h03, x[1]) ^ x[2] ^ x[3];
        b[4*c+1] = x[0] ^ gmul(8'h02, x[1]) ^ gmul(8'h03, x[2]) ^ x[3];
        b[4*c+2] = x[0] ^ x[1] ^ gmul(8'h02, x[2]) ^ gmul(8'h03, x[3]);
        b[4*c+3] = gmul(8'h03, x[0]) ^ x[1] ^ x[2] ^ gmul(8'h02, x[3]);
      end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign rk_in     = rk_idx <= 4'd10 ? rk_tab[rk_idx] : '0;
  assign dp_result = aes_round(dp_state, rk_in, dp_final);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] pt, input logic [127:0] exp);
    in_valid = 1;
    pt_in    = pt;
    next_exp = exp;
    chk("accept_ready", 128'(in_ready), 128'd1);
    acc = cyc + 1;
    tick();
    in_valid = 0;
    chk("ark_state", ct_out, pt ^ rk_tab[0]);
  endtask

  task automatic wait_out(input int want);
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    chk("out_valid_seen", 128'(out_valid), 128'd1);
    chk("latency", 128'(cyc - acc), 128'(want));
  endtask

  // Scoreboard and dp_final invariant, sampled on the falling edge
  always @(negedge clk)
    if (!rst_n) sb.delete();
    else begin
      chk("dp_final_only_r10", 128'(dp_final), 128'(rk_idx == 4'd10));
      if (in_valid && in_ready) sb.push_back(next_exp);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 128'd1, 128'd0);
        else chk("ciphertext", ct_out, sb.pop_front());
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; rk_valid = 1; pt_in = '0; next_exp = '0; s_hold = '0;
    load_key(KEY_B);
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dp_final", 128'(dp_final), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd0);
    chk("rst_ct_out", ct_out, 128'd0);
    chk("rst_dp_state", dp_state, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1;
    tick();
    // FIPS-197 App. B, no stalls
    accept(PT_B, CT_B);
    chk("fips_b_e0", ct_out, ARK_B);
    chk("busy_in_round", 128'(busy), 128'd1);
    wait_out(10);
    chk("ct_fips_b", ct_out, CT_B);
    tick();
    chk("idle_out_valid", 128'(out_valid), 128'd0);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_busy", 128'(busy), 128'd0);
    // No keys in IDLE: nothing accepted
    s_hold = ct_out;
    rk_valid = 0;
    in_valid = 1;
    #1;
    chk("nokey_in_ready", 128'(in_ready), 128'd0);
    tick();
    tick();
    chk("nokey_busy", 128'(busy), 128'd0);
    chk("nokey_state", ct_out, s_hold);
    in_valid = 0;
    rk_valid = 1;
    tick();
    // Key stall during round 5
    accept(PT_B, CT_B);
    for (int i = 0; i < 20 && rk_idx != 4'd5; i++) tick();
    chk("reach_r5", 128'(rk_idx), 128'd5);
    rk_valid = 0;
    s_hold = ct_out;
    repeat (3) begin
      tick();
      chk("stall_rk_idx", 128'(rk_idx), 128'd5);
      chk("stall_state", ct_out, s_hold);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
    end
    rk_valid = 1;
    wait_out(13);
    tick();
    // Output backpressure
    out_ready = 0;
    accept(PT_B, CT_B);
    wait_out(10);
    s_hold = ct_out;
    for (int i = 0; i < 7; i++) begin
      chk("bp_ct_stable", ct_out, s_hold);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_rk_idx", 128'(rk_idx), 128'd0);
      in_valid = ~i[0];
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    // Back-to-back with in_valid held; key swapped while the first block sits in DONE
    in_valid = 1;
    pt_in = PT_B;
    next_exp = CT_B;
    chk("b2b_ready", 128'(in_ready), 128'd1);
    a1 = cyc + 1;
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    chk("b2b_first_out", 128'(out_valid), 128'd1);
    load_key(KEY_C);
    pt_in = PT_C;
    next_exp = CT_C;
    for (int i = 0; i < 5 && !in_ready; i++) tick();
    chk("b2b_ready2", 128'(in_ready), 128'd1);
    chk("b2b_spacing", 128'(cyc + 1 - a1), 128'd12);
    acc = cyc + 1;
    tick();
    in_valid = 0;
    wait_out(10);
    chk("ct_fips_c1", ct_out, CT_C);
    tick();
    // Asynchronous reset in round 6
    load_key(KEY_B);
    accept(PT_B, CT_B);
    for (int i = 0; i < 20 && rk_idx != 4'd6; i++) tick();
    chk("reach_r6", 128'(rk_idx), 128'd6);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_state", ct_out, 128'd0);
    chk("arst_rk_idx", 128'(rk_idx), 128'd0);
    chk("arst_dp_final", 128'(dp_final), 128'd0);
    tick();
    chk("arst_hold_state", dp_state, 128'd0);
    rst_n = 1;
    tick();
    accept(PT_B, CT_B);
    chk("post_rst_e0", ct_out, ARK_B);
    wait_out(10);
    chk("post_rst_ct", ct_out, CT_B);
    tick();
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
